// File: rtl/red_prec.sv
// Streaming precision reduction: stage 1 rounds and shifts at input width + 1, stage 2 clamps and truncates.
// Valid/ready elastic pipeline with per-beat saturation flag and a saturating event counter.
module red_prec #(
  parameter string       I_DTYPE   = "INT",
  parameter int unsigned I_PREC    = 32,
  parameter string       O_DTYPE   = "INT",
  parameter int unsigned O_PREC    = 16,
  parameter bit          SIGNED    = 1'b1,
  parameter int unsigned FRAC_DROP = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [I_PREC-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [O_PREC-1:0] out,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sat_cnt
);

  localparam int unsigned W1 = I_PREC + 1;
  localparam bit IS_BOOL = (I_DTYPE == "BOOL");
  localparam logic [W1-1:0] HALF = (FRAC_DROP == 0) ? '0 : (W1'(1) << (FRAC_DROP - 1));

  if (I_DTYPE == "FP" || O_DTYPE == "FP") begin : g_fp_err
    $error("red_prec: FP data type is not supported");
  end
  if (I_DTYPE != O_DTYPE) begin : g_dtype_err
    $error("red_prec: input and output data types must match");
  end
  if (O_PREC > I_PREC) begin : g_prec_err
    $error("red_prec: O_PREC must not exceed I_PREC");
  end
  if ((I_DTYPE != "FXP" && FRAC_DROP != 0) || FRAC_DROP >= I_PREC) begin : g_frac_err
    $error("red_prec: illegal FRAC_DROP for this configuration");
  end

  logic              s1_valid;
  logic [W1-1:0]     s1_d;
  logic              s1_move;
  logic              accept;
  logic [W1-1:0]     ext;
  logic [W1-1:0]     sum;
  logic signed [W1-1:0] sum_s;
  logic [W1-1:0]     rnd;
  logic [O_PREC-1:0] out_n;
  logic              sat_n;

  assign s1_move  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s1_move;
  assign accept   = in_valid && in_ready;

  // HALF is zero when nothing is dropped, so INT/BOOL share the rounding path as a plain extension.
  always_comb begin
    ext   = SIGNED ? {in[I_PREC-1], in} : {1'b0, in};
    sum   = ext + HALF;
    sum_s = $signed(sum);
    if (SIGNED) rnd = sum_s >>> FRAC_DROP;
    else        rnd = sum >> FRAC_DROP;
  end

  always_comb begin
    sat_n = 1'b0;
    out_n = s1_d[O_PREC-1:0];
    if (IS_BOOL) begin
      out_n    = '0;
      out_n[0] = s1_d[0];
    end else if (SIGNED) begin
      // In range iff all bits from the output sign bit upward agree.
      if (!(&s1_d[W1-1:O_PREC-1] || ~|s1_d[W1-1:O_PREC-1])) begin
        sat_n               = 1'b1;
        out_n               = {O_PREC{~s1_d[W1-1]}};
        out_n[O_PREC-1]     = s1_d[W1-1];
      end
    end else if (|s1_d[W1-1:O_PREC]) begin
      sat_n = 1'b1;
      out_n = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      s1_valid  <= 1'b0;
      s1_d      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_sat   <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      if (accept) s1_d <= rnd;
      s1_valid <= accept || (s1_valid && !s1_move);
      if (s1_move) begin
        out     <= out_n;
        out_sat <= sat_n;
      end
      out_valid <= s1_move || (out_valid && !out_ready);
      if (cnt_clr)
        sat_cnt <= '0;
      else if (out_valid && out_ready && out_sat && !(&sat_cnt))
        sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_red_prec.sv
// Bench for red_prec: four configurations share one stimulus stream and are compared every cycle
// against a queue-based reference of the reduction rules and pipeline timing.
module tb_red_prec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;

  logic [15:0] dout [4];
  logic        dsat [4];
  logic        dval [4];
  logic        drdy [4];
  logic [15:0] dcnt [4];
  logic [15:0] cnt_i, cnt_s, cnt_u;
  logic [1:0]  cnt_c2;

  assign dcnt[0] = cnt_i;
  assign dcnt[1] = cnt_s;
  assign dcnt[2] = cnt_u;
  assign dcnt[3] = {14'b0, cnt_c2};

  always #5 clk = ~clk;

  red_prec #(.I_DTYPE("INT"), .I_PREC(32), .O_DTYPE("INT"), .O_PREC(16), .SIGNED(1'b1),
             .FRAC_DROP(0), .CNT_W(16)) u_int (
    .clk(clk), .reset_(rst_n), .in(din), .in_valid(in_valid), .in_ready(drdy[0]),
    .out(dout[0]), .out_sat(dsat[0]), .out_valid(dval[0]), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .sat_cnt(cnt_i));

  red_prec #(.I_DTYPE("FXP"), .I_PREC(32), .O_DTYPE("FXP"), .O_PREC(16), .SIGNED(1'b1),
             .FRAC_DROP(8), .CNT_W(16)) u_fxs (
    .clk(clk), .reset_(rst_n), .in(din), .in_valid(in_valid), .in_ready(drdy[1]),
    .out(dout[1]), .out_sat(dsat[1]), .out_valid(dval[1]), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .sat_cnt(cnt_s));

  red_prec #(.I_DTYPE("FXP"), .I_PREC(32), .O_DTYPE("FXP"), .O_PREC(16), .SIGNED(1'b0),
             .FRAC_DROP(8), .CNT_W(16)) u_fxu (
    .clk(clk), .reset_(rst_n), .in(din), .in_valid(in_valid), .in_ready(drdy[2]),
    .out(dout[2]), .out_sat(dsat[2]), .out_valid(dval[2]), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .sat_cnt(cnt_u));

  red_prec #(.I_DTYPE("INT"), .I_PREC(32), .O_DTYPE("INT"), .O_PREC(16), .SIGNED(1'b1),
             .FRAC_DROP(0), .CNT_W(2)) u_c2 (
    .clk(clk), .reset_(rst_n), .in(din), .in_valid(in_valid), .in_ready(drdy[3]),
    .out(dout[3]), .out_sat(dsat[3]), .out_valid(dval[3]), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .sat_cnt(cnt_c2));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference reduction: {sat, out} for config 0/3 INT signed, 1 FXP signed >>8, 2 FXP unsigned >>8.
  function automatic logic [16:0] ref_fn(input int cfg, input logic [31:0] d);
    longint v;
    logic [15:0] o;
    logic s;
    case (cfg)
      1:       v = (longint'($signed(d)) + 128) >>> 8;
      2:       v = (longint'({32'b0, d}) + 128) >>> 8;
      default: v = longint'($signed(d));
    endcase
    s = 1'b0;
    o = v[15:0];
    if (cfg == 2) begin
      if (v > 65535) begin s = 1'b1; o = 16'hFFFF; end
    end else if (v > 32767) begin
      s = 1'b1; o = 16'h7FFF;
    end else if (v < -32768) begin
      s = 1'b1; o = 16'h8000;
    end
    return {s, o};
  endfunction

  function automatic int cmax(input int cfg);
    return (cfg == 3) ? 3 : 65535;
  endfunction

  // Pipeline reference: accepted beats wait in a queue and become visible one edge after acceptance.
  typedef struct { logic [31:0] d; int rdy; } beat_t;
  beat_t q[$];
  int cyc = 0;
  int cnt [4] = '{0, 0, 0, 0};
  int n_acc = 0;
  int n_dout = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cyc = 0;
      foreach (cnt[i]) cnt[i] = 0;
      n_acc = 0;
      n_dout = 0;
    end else begin
      logic mv, mr, xfer;
      logic [16:0] r;
      mv = (q.size() > 0) && (q[0].rdy <= cyc);
      mr = (q.size() < 2) || out_ready;
      xfer = mv && out_ready;
      for (int i = 0; i < 4; i++) begin
        r = xfer ? ref_fn(i, q[0].d) : 17'h0;
        if (cnt_clr) cnt[i] = 0;
        else if (xfer && r[16] && cnt[i] < cmax(i)) cnt[i]++;
      end
      if (xfer) void'(q.pop_front());
      if (in_valid && mr) begin
        q.push_back('{d: din, rdy: cyc + 2});
        n_acc++;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic mv, mr;
    logic [16:0] e;
    mv = (q.size() > 0) && (q[0].rdy <= cyc);
    mr = (q.size() < 2) || out_ready;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d.in_ready", i), 32'(drdy[i]), 32'(mr));
      chk($sformatf("u%0d.out_valid", i), 32'(dval[i]), 32'(mv));
      if (mv) begin
        e = ref_fn(i, q[0].d);
        chk($sformatf("u%0d.out", i), 32'(dout[i]), 32'(e[15:0]));
        chk($sformatf("u%0d.out_sat", i), 32'(dsat[i]), 32'(e[16]));
      end
      chk($sformatf("u%0d.sat_cnt", i), 32'(dcnt[i]), 32'(cnt[i]));
    end
    if (dval[0] && out_ready) n_dout++;
  end

  task automatic drive(input logic [31:0] d, input logic v, input logic r, input logic c);
    din = d; in_valid = v; out_ready = r; cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  typedef struct { int cfg; logic [31:0] d; logic [16:0] e; } pin_t;
  pin_t pins [10] = '{
    '{0, 32'h00001234, 17'h01234}, '{0, 32'h00010000, 17'h17FFF},
    '{0, 32'hFFFF0000, 17'h18000}, '{0, 32'hFFFFFFFF, 17'h0FFFF},
    '{1, 32'h00000180, 17'h00002}, '{1, 32'hFFFFFE80, 17'h0FFFF},
    '{1, 32'h7FFFFFFF, 17'h17FFF}, '{2, 32'hFFFFFF00, 17'h1FFFF},
    '{1, 32'h007FFF80, 17'h17FFF}, '{1, 32'hFF7FFF7F, 17'h18000}};

  logic [31:0] vecs [14] = '{
    32'h00001234, 32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000180, 32'hFFFFFE80,
    32'h7FFFFFFF, 32'hFFFFFF00, 32'h007FFF80, 32'h007FFF7F, 32'hFF7FFF80, 32'hFF7FFF7F,
    32'h00007FFF, 32'hFFFF8000};

  initial begin
    foreach (pins[k])
      chk($sformatf("model_pin%0d", k), 32'(ref_fn(pins[k].cfg, pins[k].d)), 32'(pins[k].e));

    #2;
    chk("reset_in_ready", 32'(drdy[0]), 32'd1);
    chk("reset_out_valid", 32'(dval[0]), 32'd0);
    chk("reset_out", 32'(dout[0]), 32'd0);
    chk("reset_sat_cnt", 32'(dcnt[0]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    drive(32'h00001234, 1'b1, 1'b1, 1'b0);
    chk("lat_edge_n_valid", 32'(dval[0]), 32'd0);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("lat_edge_n1_valid", 32'(dval[0]), 32'd1);
    chk("lat_edge_n1_out", 32'(dout[0]), 32'h1234);
    drive(32'h0, 1'b0, 1'b1, 1'b0);

    foreach (vecs[k]) drive(vecs[k], 1'b1, 1'b1, 1'b0);
    repeat (3) drive(32'h0, 1'b0, 1'b1, 1'b0);

    drive(32'h11, 1'b1, 1'b0, 1'b0);
    drive(32'h22, 1'b1, 1'b0, 1'b0);
    drive(32'h33, 1'b1, 1'b0, 1'b0);
    chk("bp_in_ready_low", 32'(drdy[0]), 32'd0);
    chk("bp_out_holds_a", 32'(dout[0]), 32'h11);
    drive(32'h33, 1'b1, 1'b0, 1'b0);
    chk("bp_still_holds_a", 32'(dout[0]), 32'h11);
    drive(32'h33, 1'b1, 1'b1, 1'b0);
    chk("bp_next_is_b", 32'(dout[0]), 32'h22);
    repeat (3) drive(32'h0, 1'b0, 1'b1, 1'b0);

    drive(32'h0, 1'b0, 1'b1, 1'b1);
    repeat (5) drive(32'h00010000, 1'b1, 1'b1, 1'b0);
    repeat (3) drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("cnt_five", 32'(dcnt[0]), 32'd5);
    chk("cnt_w2_holds", 32'(dcnt[3]), 32'd3);
    drive(32'h00010000, 1'b1, 1'b1, 1'b0);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    drive(32'h0, 1'b0, 1'b1, 1'b1);
    chk("cnt_clr_priority", 32'(dcnt[0]), 32'd0);

    drive(32'h00010000, 1'b1, 1'b1, 1'b0);
    drive(32'h00010000, 1'b1, 1'b1, 1'b0);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    drive(32'h11, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("pre_reset_full", 32'(drdy[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(dval[0]), 32'd0);
    chk("async_rst_out", 32'(dout[0]), 32'd0);
    chk("async_rst_out_sat", 32'(dsat[0]), 32'd0);
    chk("async_rst_sat_cnt", 32'(dcnt[0]), 32'd0);
    chk("async_rst_in_ready", 32'(drdy[0]), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    chk("post_rst_lat_n", 32'(dval[0]), 32'd0);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_lat_n1", 32'(dval[0]), 32'd1);
    chk("post_rst_out", 32'(dout[0]), 32'hFFFF);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 1) == 0) ? vecs[$urandom_range(0, 13)] : $urandom;
      drive(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    repeat (5) drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("model_drained", 32'(q.size()), 32'd0);
    chk("beats_in_eq_out", 32'(n_dout), 32'(n_acc));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
